sipo_rx: RTL

//  Serial-in parallel-out word receiver; the receive-side counterpart of the piso shifter.
//  - Framing: samples serial_in on qualified strobes and assembles SIZE-bit words MSB-first.
//  - Output: presents each complete word through a valid/ready handshake.
//  - Double buffering: shift register and output register are separate, so reception continues while a word waits.
//  - Use: receives driver read-back (e.g. stepper-driver SPI MISO) in the core clock domain.

---
 rtl/sipo_rx_pkg.sv | 13 +
 rtl/sipo_rx.sv | 121 ++++++++++++
 2 files changed

// File: rtl/sipo_rx_pkg.sv
// Shared definitions for the serial receive/transmit word path.
// State encodings and the default word width are common to the
// parallel-in (piso) and parallel-out (sipo) sides.
package sipo_rx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_SIZE = 8;

endpackage

// File: rtl/sipo_rx.sv
// Serial-in parallel-out word receiver.
// Samples serial_in on qualified strobes, assembles SIZE-bit words and
// hands them out through a valid/ready stage. The shift register and the
// output register are separate, so a new word can be assembled while the
// previous one is still waiting for the consumer.
//
//   state    | meaning
//   ST_IDLE  | no frame active, bit counter and shift register cleared
//   ST_SHIFT | frame active, collecting bits (busy_out high)
module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int SIZE      = DEFAULT_SIZE,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk_in,
  input  logic            reset_n_in,
  input  logic            serial_in,
  input  logic            shift_en_in,
  input  logic            frame_in,
  input  logic            ready_in,
  input  logic            clear_overrun_in,
  output logic [SIZE-1:0] data_out,
  output logic            valid_out,
  output logic            overrun_out,
  output logic            busy_out
);

  localparam int CW = $clog2(SIZE + 1);

  state_t            state;
  logic [CW-1:0]     bit_cnt;
  logic [SIZE-1:0]   shift_reg;
  logic [SIZE-1:0]   word_next;
  logic              sample;
  logic              complete;

  // A sample is taken in IDLE too: the cycle that raises frame_in may
  // already carry the first strobe.
  assign sample   = frame_in & shift_en_in;
  assign complete = sample && (bit_cnt == CW'(SIZE - 1));

  // Word as it stands after shifting in the current serial bit.
  generate
    if (SIZE == 1) begin : g_single
      assign word_next = serial_in;
    end else if (MSB_FIRST) begin : g_msb
      assign word_next = {shift_reg[SIZE-2:0], serial_in};
    end else begin : g_lsb
      assign word_next = {serial_in, shift_reg[SIZE-1:1]};
    end
  endgenerate

  // Frame tracking, bit counter and shift register.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state     <= ST_IDLE;
      busy_out  <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_in) begin
            state    <= ST_SHIFT;
            busy_out <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (!frame_in) begin
            state    <= ST_IDLE;
            busy_out <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          busy_out <= 1'b0;
        end
      endcase

      // Dropping the frame throws away any partial word.
      if (!frame_in) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
      end else if (sample) begin
        if (complete) begin
          bit_cnt   <= '0;
          shift_reg <= '0;
        end else begin
          bit_cnt   <= bit_cnt + CW'(1);
          shift_reg <= word_next;
        end
      end
    end
  end

  // Output stage: load on completion if the slot is free or being
  // consumed this cycle, otherwise drop the word and flag overrun.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      data_out    <= '0;
      valid_out   <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      if (complete && (!valid_out || ready_in)) begin
        data_out  <= word_next;
        valid_out <= 1'b1;
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end

      // A new overrun takes priority over a clear in the same cycle.
      if (complete && valid_out && !ready_in) begin
        overrun_out <= 1'b1;
      end else if (clear_overrun_in) begin
        overrun_out <= 1'b0;
      end
    end
  end

endmodule
